// File: rtl/calc_agg.sv
// Bit-serial +/-1 aggregator: saturating signed accumulator feeding the ALU,
// with a sign-based activation bit decoded from the registered sum.
module calc_agg #(
  parameter int alu_width = 12,
  parameter int agg_width = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_1,
  input  logic                 calc_in,
  output logic [alu_width-1:0] agg_out2alu,
  output logic                 agg_out_acted
);

  localparam logic [agg_width-1:0] one     = agg_width'(1);
  localparam logic [agg_width-1:0] agg_max = {1'b0, {(agg_width-1){1'b1}}};
  localparam logic [agg_width-1:0] agg_min = {1'b1, {(agg_width-1){1'b0}}};

  logic signed [agg_width-1:0] acc;
  logic signed [agg_width-1:0] acc_next;
  logic                        at_max;
  logic                        at_min;

  assign at_max = (acc == agg_max);
  assign at_min = (acc == agg_min);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (calc_1) begin
      if (calc_in) begin
        if (!at_max) acc_next = acc + one;
      end else begin
        if (!at_min) acc_next = acc - one;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= '0;
    else      acc <= acc_next;
  end

  // Strictly positive: sign clear and not zero.
  assign agg_out_acted = ~acc[agg_width-1] & (acc != '0);

  generate
    if (alu_width >= agg_width) begin : g_extend
      assign agg_out2alu = alu_width'(acc);
    end else begin : g_clamp
      localparam logic signed [agg_width-1:0] alu_max =
        agg_width'((1 << (alu_width - 1)) - 1);
      localparam logic signed [agg_width-1:0] alu_min = ~alu_max;

      logic signed [agg_width-1:0] clamped;

      always_comb begin
        clamped = acc;
        if (acc > alu_max)      clamped = alu_max;
        else if (acc < alu_min) clamped = alu_min;
      end

      // In range after clamping, so dropping the upper bits keeps the value.
      assign agg_out2alu = alu_width'(clamped);
    end
  endgenerate

endmodule

// File: tb/tb_calc_agg.sv
// Directed bench for calc_agg: a 12/12 instance and an 8-bit-ALU instance
// share one stimulus stream so clamping is checked alongside the main sum.
module tb_calc_agg;

  logic        clk = 1'b0;
  logic        rst;
  logic        calc_1;
  logic        calc_in;
  logic [11:0] sum12;
  logic        acted12;
  logic [7:0]  sum8;
  logic        acted8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  calc_agg #(.alu_width(12), .agg_width(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .calc_1        (calc_1),
    .calc_in       (calc_in),
    .agg_out2alu   (sum12),
    .agg_out_acted (acted12)
  );

  calc_agg #(.alu_width(8), .agg_width(12)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .calc_1        (calc_1),
    .calc_in       (calc_in),
    .agg_out2alu   (sum8),
    .agg_out_acted (acted8)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic int s12();
    return int'($signed(sum12));
  endfunction

  function automatic int s8();
    return int'($signed(sum8));
  endfunction

  // Drive inputs away from the edge, take one edge, settle before sampling.
  task automatic step(input logic c1, input logic ci);
    calc_1  = c1;
    calc_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    static int  exp_sum[6]   = '{-1, 0, -1, 0, 1, 0};
    static int  exp_act[6]   = '{0, 0, 0, 0, 1, 0};
    static logic seq_in[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst     = 1'b0;
    calc_1  = 1'b1;
    calc_in = 1'b1;
    #2;

    // Reset held across edges with enable on: nothing accumulates.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      check($sformatf("rst_sum[%0d]", i), s12(), 0);
      check($sformatf("rst_act[%0d]", i), int'(acted12), 0);
    end

    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq_in[i]);
      check($sformatf("seq_sum[%0d]", i), s12(), exp_sum[i]);
      check($sformatf("seq_act[%0d]", i), int'(acted12), exp_act[i]);
      check($sformatf("seq_sum8[%0d]", i), s8(), exp_sum[i]);
    end

    // Mid-stream asynchronous reset between edges.
    step(1'b1, 1'b1);
    check("pre_rst_sum", s12(), 1);
    rst = 1'b0;
    #1;
    check("async_rst_sum", s12(), 0);
    check("async_rst_act", int'(acted12), 0);
    rst = 1'b1;
    step(1'b1, 1'b1);
    check("post_rst_sum", s12(), 1);
    check("post_rst_act", int'(acted12), 1);

    // Hold: enable low, calc_in toggling.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'(i % 2 == 0 ? 0 : 1));
      check($sformatf("hold_sum[%0d]", i), s12(), 1);
      check($sformatf("hold_act[%0d]", i), int'(acted12), 1);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("hold_then_dec", s12(), 0);

    // Positive saturation, with the 8-bit view clamped on the way.
    reset_pulse();
    for (int i = 1; i <= 2100; i++) begin
      step(1'b1, 1'b1);
      if (i == 300) begin
        check("up300_sum12", s12(), 300);
        check("up300_sum8", s8(), 127);
        check("up300_act8", int'(acted8), 1);
      end
      if (i == 2048) check("sat_hi_edge", s12(), 2047);
    end
    check("sat_hi_sum", s12(), 2047);
    check("sat_hi_raw", int'(sum12), 'h7FF);
    check("sat_hi_act", int'(acted12), 1);
    check("sat_hi_sum8", s8(), 127);

    // Negative saturation.
    for (int i = 1; i <= 4200; i++) begin
      step(1'b1, 1'b0);
      if (i == 2047) check("down_zero_act", int'(acted12), 0);
      if (i == 2347) begin
        check("dn300_sum12", s12(), -300);
        check("dn300_sum8", s8(), -128);
        check("dn300_raw8", int'(sum8), 'h80);
      end
    end
    check("sat_lo_sum", s12(), -2048);
    check("sat_lo_raw", int'(sum12), 'h800);
    check("sat_lo_act", int'(acted12), 0);
    check("sat_lo_sum8", s8(), -128);

    step(1'b1, 1'b1);
    check("leave_lo_sum", s12(), -2047);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
